// File: rtl/game_pkg.sv
// Shared definitions for the game timer controller: FSM state encodings
// and default parameter values.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_GAME = 3'd1,
    WAIT_GAME = 3'd2,
    RUN       = 3'd3,
    LOAD_END  = 3'd4,
    WAIT_END  = 3'd5,
    ENDED     = 3'd6
  } state_t;

  localparam int unsigned DEF_TICK_DIV     = 50000000;
  localparam int unsigned DEF_GAME_SECONDS = 30;
  localparam int unsigned DEF_LOAD_CYCLES  = 16;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-clock tick every TICK_DIV enabled clocks.
module tick_gen
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count enabled clocks, wrapping at TICK_DIV-1; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

  assign tick = enable & ~clear & (cnt == LAST);

endmodule

// File: rtl/game_timer_ctrl.sv
// Game timer controller: sequences load phases, counts down game seconds
// and reports expiry to the game controller.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned GAME_SECONDS = DEF_GAME_SECONDS,
  parameter int unsigned LOAD_CYCLES  = DEF_LOAD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_state,
  input  logic       game_state,
  input  logic       end_state,
  output logic       control_signal,
  output logic       timer_signal,
  output logic [7:0] seconds_left,
  output logic       busy
);

  localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] GAME_SEC  = 8'(GAME_SECONDS);

  state_t     state, next_state;
  logic       start_prev;
  logic [7:0] load_cnt, load_cnt_d, sec_d;
  logic       control_d, timer_d, busy_d;
  logic       tick, start_fall, load_done, abort;

  assign start_fall = start_prev & ~start_state;
  assign load_done  = (load_cnt == LOAD_LAST);
  assign abort      = (state != IDLE) & start_state;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state == RUN),
    .clear  (state != RUN),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a start request outside IDLE aborts to IDLE first.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      next_state = (start_fall && !game_state && !end_state) ? LOAD_GAME : IDLE;
        LOAD_GAME: next_state = load_done ? WAIT_GAME : LOAD_GAME;
        WAIT_GAME: next_state = game_state ? RUN : WAIT_GAME;
        RUN:       next_state = game_state ? RUN : LOAD_END;
        LOAD_END:  next_state = load_done ? WAIT_END : LOAD_END;
        WAIT_END:  next_state = end_state ? ENDED : WAIT_END;
        ENDED:     next_state = end_state ? ENDED : IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the load counter.
  always_comb begin
    load_cnt_d = load_cnt;
    control_d  = 1'b0;
    timer_d    = timer_signal;
    sec_d      = seconds_left;
    busy_d     = (next_state == LOAD_GAME) || (next_state == LOAD_END);
    if (abort) begin
      timer_d    = 1'b0;
      load_cnt_d = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timer_d    = 1'b0;
          load_cnt_d = 8'd0;
        end
        LOAD_GAME, LOAD_END: begin
          if (load_done) begin
            control_d  = 1'b1;
            load_cnt_d = 8'd0;
            if (state == LOAD_GAME) begin
              sec_d = GAME_SEC;
            end else begin
              sec_d = seconds_left;
            end
          end else begin
            load_cnt_d = load_cnt + 8'd1;
          end
        end
        RUN: begin
          if (!game_state) begin
            timer_d    = 1'b0;
            load_cnt_d = 8'd0;
          end else if (seconds_left == 8'd0) begin
            // Expiry is flagged the clock after the count reaches zero.
            timer_d = 1'b1;
          end else if (tick) begin
            sec_d = seconds_left - 8'd1;
          end else begin
            sec_d = seconds_left;
          end
        end
        default: begin
          load_cnt_d = load_cnt;
        end
      endcase
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_signal <= 1'b0;
      timer_signal   <= 1'b0;
      seconds_left   <= 8'd0;
      busy           <= 1'b0;
      load_cnt       <= 8'd0;
      start_prev     <= 1'b0;
    end else begin
      control_signal <= control_d;
      timer_signal   <= timer_d;
      seconds_left   <= sec_d;
      busy           <= busy_d;
      load_cnt       <= load_cnt_d;
      start_prev     <= start_state;
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed, table-driven bench for game_timer_ctrl (TICK_DIV=4, GAME_SECONDS=3,
// LOAD_CYCLES=2) plus a TICK_DIV=1 instance for the fast-tick case.
module tb_game_timer_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_state, game_state, end_state;
  logic       control_signal, timer_signal, busy;
  logic [7:0] seconds_left;
  logic       control1, timer1, busy1;
  logic [7:0] seconds1;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       s, g, e;
    logic       c, t;
    logic [7:0] sec;
    logic       b;
    state_t     st;
  } vec_t;

  vec_t vecs[$];

  game_timer_ctrl #(.TICK_DIV(4), .GAME_SECONDS(3), .LOAD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start_state(start_state), .game_state(game_state),
    .end_state(end_state), .control_signal(control_signal), .timer_signal(timer_signal),
    .seconds_left(seconds_left), .busy(busy)
  );

  game_timer_ctrl #(.TICK_DIV(1), .GAME_SECONDS(3), .LOAD_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .start_state(start_state), .game_state(game_state),
    .end_state(end_state), .control_signal(control1), .timer_signal(timer1),
    .seconds_left(seconds1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic g, logic e, logic c, logic t,
                              logic [7:0] sec, logic b, state_t st);
    vec_t v;
    v.s = s; v.g = g; v.e = e; v.c = c; v.t = t; v.sec = sec; v.b = b; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic ac, input logic at,
                       input logic [7:0] asec, input logic ab, input state_t ast,
                       input logic ec, input logic et, input logic [7:0] esec,
                       input logic eb, input state_t est);
    tests++;
    if (ac !== ec || at !== et || asec !== esec || ab !== eb || ast !== est) begin
      failed++;
      $display("FAIL %s: got ctrl=%b timer=%b sec=%0d busy=%b state=%0d, expected ctrl=%b timer=%b sec=%0d busy=%b state=%0d",
               name, ac, at, asec, ab, ast, ec, et, esec, eb, est);
    end
  endtask

  // Drive inputs, then sample one time unit after the next rising edge.
  task automatic step(input logic s, input logic g, input logic e);
    start_state = s; game_state = g; end_state = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_state = 1'b0; game_state = 1'b0; end_state = 1'b0;
    #3;
    check("reset_state", control_signal, timer_signal, seconds_left, busy, dut.state,
          1'b0, 1'b0, 8'd0, 1'b0, IDLE);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Full game flow: ignored fall, load, countdown, expiry, end load, end.
    vecs.push_back(mk(1,1,0, 0,0,8'd0,0, IDLE));
    vecs.push_back(mk(0,1,0, 0,0,8'd0,0, IDLE));
    vecs.push_back(mk(1,0,0, 0,0,8'd0,0, IDLE));
    vecs.push_back(mk(0,0,0, 0,0,8'd0,1, LOAD_GAME));
    vecs.push_back(mk(0,0,0, 0,0,8'd0,1, LOAD_GAME));
    vecs.push_back(mk(0,0,0, 1,0,8'd3,0, WAIT_GAME));
    vecs.push_back(mk(0,0,0, 0,0,8'd3,0, WAIT_GAME));
    vecs.push_back(mk(0,1,0, 0,0,8'd3,0, RUN));
    for (int i = 1; i <= 14; i++) begin
      vecs.push_back(mk(0,1,0, 0, (i >= 13),
                        (i < 4) ? 8'd3 : (i < 8) ? 8'd2 : (i < 12) ? 8'd1 : 8'd0,
                        0, RUN));
    end
    vecs.push_back(mk(0,0,0, 0,0,8'd0,1, LOAD_END));
    vecs.push_back(mk(0,0,0, 0,0,8'd0,1, LOAD_END));
    vecs.push_back(mk(0,0,0, 1,0,8'd0,0, WAIT_END));
    vecs.push_back(mk(0,0,0, 0,0,8'd0,0, WAIT_END));
    vecs.push_back(mk(0,0,1, 0,0,8'd0,0, ENDED));
    vecs.push_back(mk(0,0,1, 0,0,8'd0,0, ENDED));
    vecs.push_back(mk(0,0,0, 0,0,8'd0,0, IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].g, vecs[i].e);
      check($sformatf("vec%0d", i), control_signal, timer_signal, seconds_left, busy,
            dut.state, vecs[i].c, vecs[i].t, vecs[i].sec, vecs[i].b, vecs[i].st);
    end

    // Abort from RUN with two seconds left.
    step(1,0,0);
    step(0,0,0); step(0,0,0); step(0,0,0);
    step(0,1,0);
    for (int i = 0; i < 4; i++) step(0,1,0);
    check("run_sec2", control_signal, timer_signal, seconds_left, busy, dut.state,
          1'b0, 1'b0, 8'd2, 1'b0, RUN);
    step(1,1,0);
    check("abort_idle", control_signal, timer_signal, seconds_left, busy, dut.state,
          1'b0, 1'b0, 8'd2, 1'b0, IDLE);
    step(1,0,0);
    check("abort_hold", control_signal, timer_signal, seconds_left, busy, dut.state,
          1'b0, 1'b0, 8'd2, 1'b0, IDLE);

    // Short reset pulse in the middle of LOAD_GAME.
    step(0,0,0);
    check("load_busy", control_signal, timer_signal, seconds_left, busy, dut.state,
          1'b0, 1'b0, 8'd2, 1'b1, LOAD_GAME);
    #2 reset = 1'b1;
    #1;
    check("async_reset", control_signal, timer_signal, seconds_left, busy, dut.state,
          1'b0, 1'b0, 8'd0, 1'b0, IDLE);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0,0,0);
      check($sformatf("post_reset%0d", i), control_signal, timer_signal, seconds_left,
            busy, dut.state, 1'b0, 1'b0, 8'd0, 1'b0, IDLE);
    end

    // TICK_DIV=1 instance: one second per RUN clock.
    step(1,0,0);
    step(0,0,0); step(0,0,0); step(0,0,0);
    step(0,1,0);
    check("fast_entry", control1, timer1, seconds1, busy1, dut1.state,
          1'b0, 1'b0, 8'd3, 1'b0, RUN);
    for (int i = 1; i <= 5; i++) begin
      step(0,1,0);
      check($sformatf("fast_run%0d", i), control1, timer1, seconds1, busy1, dut1.state,
            1'b0, (i >= 4), (i >= 3) ? 8'd0 : 8'(3 - i), 1'b0, RUN);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning clocks per countdown second; the legal range SHALL be 1 to 2^26-1.
REQ-002 The block SHALL have parameter GAME_SECONDS, default 30, meaning game length in seconds; the legal range SHALL be 1 to 255.
REQ-003 The block SHALL have parameter LOAD_CYCLES, default 16, meaning clocks spent initialising per transition; the legal range SHALL be 1 to 255.
REQ-004 Port clk, input, 1 bit, SHALL be the single system clock.
REQ-005 Port reset, input, 1 bit, SHALL be the reset, asynchronous and active-high.
REQ-006 Port start_state, input, 1 bit, SHALL carry the game controller's Start-state indication.
REQ-007 Port game_state, input, 1 bit, SHALL carry the game controller's Game-state indication.
REQ-008 Port end_state, input, 1 bit, SHALL carry the game controller's GameEnd-state indication.
REQ-009 Port control_signal, output, 1 bit, SHALL be a one-clock "load done" pulse to the controller.
REQ-010 Port timer_signal, output, 1 bit, SHALL be the game-time-expired level to the controller.
REQ-011 Port seconds_left, output, 8 bits, SHALL be the remaining game seconds, for the display.
REQ-012 Port busy, output, 1 bit, SHALL be high in LOAD_GAME and LOAD_END.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD_GAME, WAIT_GAME, RUN, LOAD_END, WAIT_END and ENDED, and the reset state SHALL be IDLE.
REQ-014 IDLE SHALL go to LOAD_GAME on the cycle after start_state is sampled falling (1 to 0) while game_state=0 and end_state=0, and a load counter SHALL be cleared on that transition.
REQ-015 LOAD_GAME SHALL count exactly LOAD_CYCLES clocks, then drive control_signal=1 for exactly one clock, load seconds_left=GAME_SECONDS, and go to WAIT_GAME.
REQ-016 WAIT_GAME SHALL go to RUN when game_state=1, clearing the prescaler.
REQ-017 In RUN, the prescaler SHALL count 0 to TICK_DIV-1; at TICK_DIV-1 it SHALL wrap to 0 and decrement seconds_left, which SHALL saturate at 0 and never wrap.
REQ-018 timer_signal SHALL be registered, SHALL rise on the clock after seconds_left reaches 0, and SHALL hold high until game_state falls.
REQ-019 In RUN, when game_state falls the block SHALL clear timer_signal, clear the load counter, and go to LOAD_END.
REQ-020 LOAD_END SHALL count LOAD_CYCLES clocks, pulse control_signal for one clock, and go to WAIT_END.
REQ-021 WAIT_END SHALL go to ENDED when end_state=1.
REQ-022 ENDED SHALL go to IDLE when end_state falls.
REQ-023 In any non-IDLE state, start_state=1 SHALL force IDLE on the next clock with control_signal=0 and timer_signal=0; this abort SHALL take priority over all other transitions.
REQ-024 control_signal SHALL never be high for two consecutive clocks.
REQ-025 Outside RUN, seconds_left SHALL hold its value.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While reset=1, the block SHALL hold state=IDLE, control_signal=0, timer_signal=0, seconds_left=0, busy=0, and all counters at 0.
REQ-028 Reset asserted mid-RUN or mid-LOAD SHALL take effect without waiting for a clock edge, and after release the block SHALL restart from IDLE, with no control_signal pulse emitted.
REQ-029 The previous-value registers used for edge detection SHALL reset to 0, so that a start_state held at 1 through reset release produces no spurious fall.

Structure
REQ-030 The state encodings (3 bits) and parameter defaults SHALL live in the shared package game_pkg.
REQ-031 The prescaler SHALL be a sub-module, tick_gen (inputs clk, reset, enable, clear; output tick, a one-clock pulse every TICK_DIV enabled clocks).

Verification (TICK_DIV=4, GAME_SECONDS=3, LOAD_CYCLES=2)
REQ-032 start_state 1->0 -> busy high for 2 clocks, then control_signal high for exactly 1 clock and seconds_left=3.
REQ-033 game_state=1 held -> seconds_left goes 3,2,1,0 at 4-clock spacing, and timer_signal rises 1 clock after seconds_left reaches 0.
REQ-034 game_state falls while timer_signal=1 -> timer_signal low next clock, and control_signal pulses once 2 clocks later; end_state 1 then 0 -> state returns to IDLE.
REQ-035 start_state=1 during RUN with seconds_left=2 -> IDLE next clock, timer_signal=0, and seconds_left holds 2.
REQ-036 reset pulsed for less than 1 clock mid-LOAD_GAME -> all outputs 0 immediately, and no control_signal pulse follows.
REQ-037 TICK_DIV=1 -> seconds_left decrements every RUN clock and timer_signal rises 4 clocks after RUN entry.
